alu_multicycle: RTL and testbench

//  Parametrised successor to the 8-bit bus ALU. Adds start/busy/done handshake,

---
 rtl/alu_multicycle.sv | 254 +++++++++++++++++++++++++
 tb/tb_alu_multicycle.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_multicycle.sv
// Purpose: bus ALU with start/busy/done handshake; ADD/SUB/AND/OR/XOR/CMP complete in one
//   cycle, MUL (shift-add) and DIV (restoring) iterate one bit per cycle.
// Latency: result/flags/done visible 1 cycle after start for single ops, REG_WIDTH cycles for MUL/DIV.
// Backpressure: none queued; start is only sampled in IDLE, so a start while busy is dropped.
// Ports: clk/clr (sync active-high reset), start/fn/reg_A/reg_B request, en gates the
//   tri-state bus; rem, flags {Z,C,N,V}, dz, busy, done are registered status outputs.
module alu_multicycle #(
  parameter int REG_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 clr,
  input  logic                 start,
  input  logic [2:0]           fn,
  input  logic [REG_WIDTH-1:0] reg_A,
  input  logic [REG_WIDTH-1:0] reg_B,
  input  logic                 en,
  output logic [REG_WIDTH-1:0] bus,
  output logic [REG_WIDTH-1:0] rem,
  output logic [3:0]           flags,
  output logic                 dz,
  output logic                 busy,
  output logic                 done
);

  localparam int W  = REG_WIDTH;
  localparam int CW = (W > 2) ? $clog2(W) : 1;

  localparam logic [2:0] FN_ADD = 3'd0;
  localparam logic [2:0] FN_SUB = 3'd1;
  localparam logic [2:0] FN_MUL = 3'd2;
  localparam logic [2:0] FN_DIV = 3'd3;
  localparam logic [2:0] FN_AND = 3'd4;
  localparam logic [2:0] FN_OR  = 3'd5;
  localparam logic [2:0] FN_XOR = 3'd6;
  localparam logic [2:0] FN_CMP = 3'd7;

  typedef enum logic {IDLE, CALC} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;       // iterations already performed
  logic            is_div_q, is_div_d;
  // Shared iteration registers: MUL uses x=product acc, y=shifted multiplicand, z=multiplier;
  // DIV uses x=partial remainder, y=dividend/quotient shift register, z=divisor.
  logic [2*W-1:0]  x_q, x_d;
  logic [2*W-1:0]  y_q, y_d;
  logic [W-1:0]    z_q, z_d;
  logic [W-1:0]    result_q, result_d;
  logic [W-1:0]    rem_q, rem_d;
  logic [3:0]      flags_q, flags_d;
  logic            dz_q, dz_d;
  logic            done_q, done_d;

  // Iteration datapath
  logic [2*W-1:0]  mul_acc_in, mul_mcand_in, mul_acc_out, mul_mcand_out;
  logic [W-1:0]    mul_mplier_in, mul_mplier_out;
  logic [W-1:0]    div_r_in, div_q_in, div_d_in, div_r_out, div_q_out;
  logic [W:0]      div_trial, div_sub;
  logic            div_ge;

  // Single-cycle datapath and commit bundle
  logic [W:0]      sum, diff;
  logic            commit, upd_res;
  logic [W-1:0]    res_v;
  logic            c_v, v_v, dz_v;

  always_comb begin
    // In IDLE the first iteration is taken straight from the operand inputs so that the
    // final write lands on the REG_WIDTH-th edge counting the start edge.
    if (state_q == IDLE) begin
      mul_acc_in    = '0;
      mul_mcand_in  = {{W{1'b0}}, reg_A};
      mul_mplier_in = reg_B;
      div_r_in      = '0;
      div_q_in      = reg_A;
      div_d_in      = reg_B;
    end else begin
      mul_acc_in    = x_q;
      mul_mcand_in  = y_q;
      mul_mplier_in = z_q;
      div_r_in      = x_q[W-1:0];
      div_q_in      = y_q[W-1:0];
      div_d_in      = z_q;
    end

    mul_acc_out    = mul_acc_in + (mul_mplier_in[0] ? mul_mcand_in : '0);
    mul_mcand_out  = {mul_mcand_in[2*W-2:0], 1'b0};
    mul_mplier_out = {1'b0, mul_mplier_in[W-1:1]};

    // Restoring step: partial remainder stays below the divisor, so W bits hold it.
    div_trial = {div_r_in, div_q_in[W-1]};
    div_sub   = div_trial - {1'b0, div_d_in};
    div_ge    = (div_trial >= {1'b0, div_d_in});
    div_r_out = div_ge ? div_sub[W-1:0] : div_trial[W-1:0];
    div_q_out = {div_q_in[W-2:0], div_ge};

    sum  = {1'b0, reg_A} + {1'b0, reg_B};
    diff = {1'b0, reg_A} - {1'b0, reg_B};
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    is_div_d = is_div_q;
    x_d      = x_q;
    y_d      = y_q;
    z_d      = z_q;
    result_d = result_q;
    rem_d    = rem_q;
    flags_d  = flags_q;
    dz_d     = dz_q;
    done_d   = 1'b0;
    commit   = 1'b0;
    upd_res  = 1'b0;
    res_v    = '0;
    c_v      = 1'b0;
    v_v      = 1'b0;
    dz_v     = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          case (fn)
            FN_ADD: begin
              commit  = 1'b1;
              upd_res = 1'b1;
              res_v   = sum[W-1:0];
              c_v     = sum[W];
              v_v     = (reg_A[W-1] == reg_B[W-1]) && (sum[W-1] != reg_A[W-1]);
            end
            FN_SUB, FN_CMP: begin
              commit  = 1'b1;
              upd_res = (fn == FN_SUB);   // CMP reports flags of the difference only
              res_v   = diff[W-1:0];
              c_v     = diff[W];
              v_v     = (reg_A[W-1] != reg_B[W-1]) && (diff[W-1] != reg_A[W-1]);
            end
            FN_AND: begin
              commit  = 1'b1;
              upd_res = 1'b1;
              res_v   = reg_A & reg_B;
            end
            FN_OR: begin
              commit  = 1'b1;
              upd_res = 1'b1;
              res_v   = reg_A | reg_B;
            end
            FN_XOR: begin
              commit  = 1'b1;
              upd_res = 1'b1;
              res_v   = reg_A ^ reg_B;
            end
            FN_MUL: begin
              state_d  = CALC;
              cnt_d    = CW'(1);
              is_div_d = 1'b0;
              x_d      = mul_acc_out;
              y_d      = mul_mcand_out;
              z_d      = mul_mplier_out;
            end
            FN_DIV: begin
              if (reg_B == '0) begin
                commit  = 1'b1;
                upd_res = 1'b1;
                res_v   = '1;
                dz_v    = 1'b1;
                rem_d   = reg_A;
              end else begin
                state_d  = CALC;
                cnt_d    = CW'(1);
                is_div_d = 1'b1;
                x_d      = {{W{1'b0}}, div_r_out};
                y_d      = {{W{1'b0}}, div_q_out};
                z_d      = div_d_in;
              end
            end
            default: ;
          endcase
        end
      end

      CALC: begin
        if (cnt_q == CW'(W - 1)) begin
          state_d = IDLE;
          commit  = 1'b1;
          upd_res = 1'b1;
          if (is_div_q) begin
            res_v = div_q_out;
            rem_d = div_r_out;
          end else begin
            res_v = mul_acc_out[W-1:0];
            c_v   = |mul_acc_out[2*W-1:W];
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
          if (is_div_q) begin
            x_d = {{W{1'b0}}, div_r_out};
            y_d = {{W{1'b0}}, div_q_out};
          end else begin
            x_d = mul_acc_out;
            y_d = mul_mcand_out;
            z_d = mul_mplier_out;
          end
        end
      end

      default: state_d = IDLE;
    endcase

    if (commit) begin
      if (upd_res) begin
        result_d = res_v;
      end
      flags_d = {(res_v == '0), c_v, res_v[W-1], v_v};
      dz_d    = dz_v;
      done_d  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      x_q      <= '0;
      y_q      <= '0;
      z_q      <= '0;
      result_q <= '0;
      rem_q    <= '0;
      flags_q  <= '0;
      dz_q     <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      is_div_q <= is_div_d;
      x_q      <= x_d;
      y_q      <= y_d;
      z_q      <= z_d;
      result_q <= result_d;
      rem_q    <= rem_d;
      flags_q  <= flags_d;
      dz_q     <= dz_d;
      done_q   <= done_d;
    end
  end

  assign bus   = en ? result_q : 'z;
  assign rem   = rem_q;
  assign flags = flags_q;
  assign dz    = dz_q;
  assign busy  = (state_q == CALC);
  assign done  = done_q;

endmodule

// File: tb/tb_alu_multicycle.sv
module tb_alu_multicycle;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         clr, start, en;
  logic [2:0]   fn;
  logic [W-1:0] reg_A, reg_B;
  wire  [W-1:0] bus;
  logic [W-1:0] rem;
  logic [3:0]   flags;
  logic         dz, busy, done;

  alu_multicycle #(.REG_WIDTH(W)) dut (
    .clk(clk), .clr(clr), .start(start), .fn(fn), .reg_A(reg_A), .reg_B(reg_B),
    .en(en), .bus(bus), .rem(rem), .flags(flags), .dz(dz), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int res;
    int rem;
    int flags;
    int dz;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  // Architectural state of the reference model
  int m_res = 0, m_rem = 0, m_flags = 0, m_dz = 0;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int to_signed(input int v);
    return (v >= 128) ? v - 256 : v;
  endfunction

  // Reference model in plain integer arithmetic; returns the completed-op snapshot.
  task automatic model(input int f, input int a, input int b, output exp_t e);
    int r, c, v, s;
    r = 0; c = 0; v = 0;
    case (f)
      0: begin
        r = (a + b) % 256; c = (a + b > 255);
        s = to_signed(a) + to_signed(b); v = (s > 127 || s < -128);
        m_res = r;
      end
      1, 7: begin
        r = (a - b + 256) % 256; c = (a < b);
        s = to_signed(a) - to_signed(b); v = (s > 127 || s < -128);
        if (f == 1) m_res = r;
      end
      2: begin
        r = (a * b) % 256; c = (a * b > 255); m_res = r;
      end
      3: begin
        if (b == 0) begin r = 255; m_rem = a; end
        else begin r = a / b; m_rem = a % b; end
        m_res = r;
      end
      4: begin r = a & b; m_res = r; end
      5: begin r = a | b; m_res = r; end
      6: begin r = a ^ b; m_res = r; end
      default: ;
    endcase
    m_dz    = (f == 3 && b == 0) ? 1 : 0;
    m_flags = ((r == 0) ? 8 : 0) + (c ? 4 : 0) + ((r >= 128) ? 2 : 0) + (v ? 1 : 0);
    e.res = m_res; e.rem = m_rem; e.flags = m_flags; e.dz = m_dz;
  endtask

  // Scoreboard monitor: every done pulse must match the oldest outstanding expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (done === 1'b1) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          e = sb.pop_front();
          if (en) chk("bus", int'(bus), e.res);
          chk("rem", int'(rem), e.rem);
          chk("flags", int'(flags), e.flags);
          chk("dz", int'(dz), e.dz);
          chk("busy_at_done", int'(busy), 0);
        end
      end
    end
  end

  // Issue one op; optionally pulse start mid-op or abort with clr during the 4th busy cycle.
  task automatic issue(input int f, input int a, input int b, input bit en_v,
                       input bit mid_start, input bit do_abort);
    exp_t e;
    bit   multi, got;
    int   busy_n, cyc;
    multi = (f == 2) || (f == 3 && b != 0);
    @(negedge clk);
    en = en_v; fn = 3'(f); reg_A = W'(a); reg_B = W'(b); start = 1'b1;
    if (!do_abort) begin
      model(f, a, b, e);
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    start = 1'b0;
    reg_A = W'($urandom); reg_B = W'($urandom); fn = 3'($urandom_range(0, 7));
    busy_n = 0; got = 0; cyc = 0;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      cyc = k;
      if (busy) busy_n++;
      if (done) begin got = 1; break; end
      if (do_abort && k == 4) begin
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        m_res = 0; m_rem = 0; m_flags = 0; m_dz = 0;
        en = 1'b1;
        #1;
        chk("abort_busy", int'(busy), 0);
        chk("abort_done", int'(done), 0);
        chk("abort_bus", int'(bus), 0);
        chk("abort_flags", int'(flags), 0);
        chk("abort_rem", int'(rem), 0);
        repeat (12) @(negedge clk);
        chk("abort_no_done_busy", int'(busy), 0);
        return;
      end
      if (mid_start && k == 3) begin
        start = 1'b1; fn = 3'd0; reg_A = 8'h11; reg_B = 8'h22;
      end
      if (mid_start && k == 4) start = 1'b0;
    end
    chk("done_seen", int'(got), 1);
    chk("latency", cyc, multi ? W : 1);
    chk("busy_cycles", busy_n, multi ? W - 1 : 0);
  endtask

  task automatic check_held(input string tag);
    @(negedge clk);
    en = 1'b1;
    #1;
    chk({tag, "_bus"}, int'(bus), m_res);
    chk({tag, "_rem"}, int'(rem), m_rem);
    chk({tag, "_flags"}, int'(flags), m_flags);
    chk({tag, "_dz"}, int'(dz), m_dz);
  endtask

  initial begin
    int f, a, b;
    bit e1;
    clr = 1'b1; start = 1'b0; en = 1'b1; fn = '0; reg_A = '0; reg_B = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_bus", int'(bus), 0);
    chk("rst_rem", int'(rem), 0);
    chk("rst_flags", int'(flags), 0);
    chk("rst_dz", int'(dz), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    clr = 1'b0;

    issue(0, 200, 100, 1, 0, 0);   // 0x2C, C set
    issue(1, 5, 7, 1, 0, 0);       // 0xFE, C N set
    issue(7, 9, 9, 1, 0, 0);       // Z only, bus keeps 0xFE
    check_held("cmp_held");
    issue(2, 20, 15, 1, 1, 0);     // 0x2C, C set; mid-op start dropped
    issue(3, 100, 7, 1, 0, 0);     // q=0x0E r=0x02
    issue(3, 55, 0, 1, 0, 0);      // divide by zero
    issue(4, 8'hF0, 8'h3C, 1, 0, 0); // clears dz, rem held
    issue(2, 255, 255, 1, 0, 1);   // aborted by clr
    check_held("after_abort");
    issue(6, 8'hA5, 8'h5A, 0, 0, 0); // en low throughout
    check_held("en_low_held");
    issue(3, 255, 1, 1, 0, 0);
    issue(2, 0, 77, 1, 0, 0);

    for (int i = 0; i < 60; i++) begin
      f  = int'($urandom_range(0, 7));
      a  = int'($urandom_range(0, 255));
      b  = int'($urandom_range(0, 255));
      if (f == 3 && $urandom_range(0, 3) == 0) b = 0;
      e1 = ($urandom_range(0, 3) != 0);
      issue(f, a, b, e1, ($urandom_range(0, 4) == 0), 0);
      if (!e1) check_held("rand_held");
    end

    repeat (3) @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
